// File: rtl/fsqrt_pipe.sv
// Pipelined IEEE-754 single-precision square root, correctly rounded, with
// valid/ready backpressure and a tag that travels beside each operation.
module fsqrt_pipe #(
    parameter int NSTAGE = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag,
    output logic             nv
);

    localparam int BPS = (25 + NSTAGE - 1) / NSTAGE;
    localparam int L   = NSTAGE - 1;

    localparam logic [1:0] SP_NORM = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_ZERO = 2'd2;
    localparam logic [1:0] SP_INF  = 2'd3;

    logic             stall;
    logic [1:0]       in_spec;
    logic [7:0]       in_exp;
    logic [49:0]      in_rad;

    logic             v_r    [NSTAGE];
    logic [24:0]      q_r    [NSTAGE];
    logic [27:0]      rem_r  [NSTAGE];
    logic [49:0]      rad_r  [NSTAGE];
    logic [7:0]       exp_r  [NSTAGE];
    logic [1:0]       spec_r [NSTAGE];
    logic             sign_r [NSTAGE];
    logic [TAG_W-1:0] tag_r  [NSTAGE];

    logic             v_n    [NSTAGE];
    logic [24:0]      q_n    [NSTAGE];
    logic [27:0]      rem_n  [NSTAGE];
    logic [49:0]      rad_n  [NSTAGE];
    logic [7:0]       exp_n  [NSTAGE];
    logic [1:0]       spec_n [NSTAGE];
    logic             sign_n [NSTAGE];
    logic [TAG_W-1:0] tag_n  [NSTAGE];

    assign out_valid = v_r[L];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // Radicand is the significand scaled by 2^25 so the integer root carries
    // 24 fraction bits: 23 for the result plus one round bit.
    always_comb begin
        in_spec = SP_NORM;
        if (x[30:23] == 8'hFF && x[22:0] != '0)
            in_spec = SP_NAN;
        else if (x[31] && x[30:23] != '0)
            in_spec = SP_NAN;
        else if (x[30:23] == '0)
            in_spec = SP_ZERO;
        else if (x[30:23] == 8'hFF)
            in_spec = SP_INF;
        in_exp = 8'(({1'b0, x[30:23]} + (x[23] ? 9'd127 : 9'd126)) >> 1);
        in_rad = x[23] ? {2'b01, x[22:0], 25'b0} : {1'b1, x[22:0], 26'b0};
    end

    // Restoring recurrence; each stage retires up to BPS root bits, taking
    // radicand bit pairs from the top of a left-shifting register.
    always_comb begin
        logic [24:0] qc;
        logic [27:0] rc;
        logic [49:0] dc;
        logic [27:0] rem_sh;
        logic [27:0] trial;
        int          p;
        qc     = '0;
        rc     = '0;
        dc     = '0;
        rem_sh = '0;
        trial  = '0;
        p      = 0;
        for (int s = 0; s < NSTAGE; s++) begin
            p = (s == 0) ? 0 : s - 1;
            if (s == 0) begin
                v_n[s]    = in_valid;
                qc        = '0;
                rc        = '0;
                dc        = in_rad;
                exp_n[s]  = in_exp;
                spec_n[s] = in_spec;
                sign_n[s] = x[31];
                tag_n[s]  = in_tag;
            end else begin
                v_n[s]    = v_r[p];
                qc        = q_r[p];
                rc        = rem_r[p];
                dc        = rad_r[p];
                exp_n[s]  = exp_r[p];
                spec_n[s] = spec_r[p];
                sign_n[s] = sign_r[p];
                tag_n[s]  = tag_r[p];
            end
            for (int j = 0; j < BPS; j++) begin
                if (s * BPS + j < 25) begin
                    rem_sh = {rc[25:0], dc[49:48]};
                    trial  = {1'b0, qc, 2'b01};
                    if (rem_sh >= trial) begin
                        rc = rem_sh - trial;
                        qc = {qc[23:0], 1'b1};
                    end else begin
                        rc = rem_sh;
                        qc = {qc[23:0], 1'b0};
                    end
                    dc = {dc[47:0], 2'b00};
                end
            end
            q_n[s]   = qc;
            rem_n[s] = rc;
            rad_n[s] = dc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTAGE; s++) begin
                v_r[s]    <= 1'b0;
                q_r[s]    <= '0;
                rem_r[s]  <= '0;
                rad_r[s]  <= '0;
                exp_r[s]  <= '0;
                spec_r[s] <= SP_NORM;
                sign_r[s] <= 1'b0;
                tag_r[s]  <= '0;
            end
        end else if (!stall) begin
            for (int s = 0; s < NSTAGE; s++) begin
                v_r[s]    <= v_n[s];
                q_r[s]    <= q_n[s];
                rem_r[s]  <= rem_n[s];
                rad_r[s]  <= rad_n[s];
                exp_r[s]  <= exp_n[s];
                spec_r[s] <= spec_n[s];
                sign_r[s] <= sign_n[s];
                tag_r[s]  <= tag_n[s];
            end
        end
    end

    // Round on q[0]; the leading root bit is always set, so a carry out of
    // the significand happens exactly when every root bit is one.
    always_comb begin
        logic [22:0] mant;
        logic        carry;
        mant  = q_r[L][23:1] + {22'b0, q_r[L][0]};
        carry = &q_r[L];
        nv    = 1'b0;
        y     = {1'b0, exp_r[L] + {7'b0, carry}, mant};
        case (spec_r[L])
            SP_NAN: begin
                y  = 32'h7FC0_0000;
                nv = 1'b1;
            end
            SP_ZERO: y = {sign_r[L], 31'b0};
            SP_INF:  y = 32'h7F80_0000;
            default: ;
        endcase
    end

    assign out_tag = tag_r[L];

endmodule

// File: tb/tb_fsqrt_pipe.sv
// Bench for fsqrt_pipe: directed table, random traffic against a real-valued
// reference, backpressure, latency/bubble and mid-flight reset sequences.
module tb_fsqrt_pipe;

    localparam int NS = 4;
    localparam int TW = 6;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        nv;
    } vec_t;

    typedef struct {
        logic [31:0]   y;
        logic          nv;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   x;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   y;
    logic [TW-1:0] out_tag;
    logic          nv;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ready_mode = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fsqrt_pipe #(.NSTAGE(NS), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_tag   (out_tag),
        .nv        (nv)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: double-precision sqrt of the exact operand, then one rounding
    // to 24 bits (double rounding is harmless for sqrt at these widths).
    function automatic logic [32:0] ref_sqrt(input logic [31:0] a);
        logic [63:0] db;
        logic [63:0] rb;
        logic [24:0] sg;
        int          eo;
        real         v;
        if (a[30:23] == 8'hFF && a[22:0] != '0) return {1'b1, 32'h7FC0_0000};
        if (a[31] && a[30:23] != '0)            return {1'b1, 32'h7FC0_0000};
        if (a[30:23] == '0)                     return {1'b0, a[31], 31'b0};
        if (a[30:23] == 8'hFF)                  return {1'b0, 32'h7F80_0000};
        db = {1'b0, 11'(int'(a[30:23]) + 896), a[22:0], 29'b0};
        v  = $sqrt($bitstoreal(db));
        rb = $realtobits(v);
        sg = {2'b01, rb[51:29]} + {24'b0, rb[28]};
        eo = int'(rb[62:52]) - 896 + int'(sg[24]);
        return {1'b0, 1'b0, 8'(eo), sg[22:0]};
    endfunction

    function automatic logic [31:0] rand_x();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       ;
            1, 2:    r = {1'b0, 8'($urandom_range(1, 254)), r[22:0]};
            3:       r = {r[31], 8'hFF, r[24] ? 23'd0 : r[22:0]};
            4:       r = {1'b0, r[24] ? 8'd55 : 8'd56, r[22:0]};
            default: r = {r[31], 8'd0, r[22:0]};
        endcase
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [31:0] xv, input logic [TW-1:0] tv, input logic [32:0] ev);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        x        = xv;
        in_tag   = tv;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("accept_wait", 32'(in_ready), 32'd1);
        if (in_ready) begin
            e.y   = ev[31:0];
            e.nv  = ev[32];
            e.tag = tv;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = $urandom;
        in_tag   = TW'($urandom);
    endtask

    task automatic issue_m(input logic [31:0] xv, input logic [TW-1:0] tv);
        issue(xv, tv, ref_sqrt(xv));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < NS + 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic lat_op(input logic [31:0] xv, input logic [TW-1:0] tv, input string nm);
        issue_m(xv, tv);
        for (int k = 1; k <= NS + 2; k++) begin
            @(negedge clk);
            chk(nm, 32'(out_valid), 32'(k == NS));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: ordered scoreboard, hold-while-stalled and ready rule.
    initial begin
        logic          pstall;
        logic [31:0]   py;
        logic [TW-1:0] pt;
        logic          pnv;
        exp_t          e;
        pstall = 1'b0;
        py     = '0;
        pt     = '0;
        pnv    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pstall = 1'b0;
            end else begin
                chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
                if (pstall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_y", y, py);
                    chk("hold_tag", 32'(out_tag), 32'(pt));
                    chk("hold_nv", 32'(nv), 32'(pnv));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("y", y, e.y);
                        chk("nv", 32'(nv), 32'(e.nv));
                        chk("tag", 32'(out_tag), 32'(e.tag));
                    end
                end
                pstall = out_valid && !out_ready;
                py     = y;
                pt     = out_tag;
                pnv    = nv;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[15];
        logic [31:0] xv;

        tbl[0]  = '{32'h4080_0000, 32'h4000_0000, 1'b0};
        tbl[1]  = '{32'h4000_0000, 32'h3FB5_04F3, 1'b0};
        tbl[2]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0};
        tbl[3]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0};
        tbl[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0};
        tbl[5]  = '{32'h0040_0000, 32'h0000_0000, 1'b0};
        tbl[6]  = '{32'hC080_0000, 32'h7FC0_0000, 1'b1};
        tbl[7]  = '{32'h7FC1_2345, 32'h7FC0_0000, 1'b1};
        tbl[8]  = '{32'h4110_0000, 32'h4040_0000, 1'b0};
        tbl[9]  = '{32'h3E80_0000, 32'h3F00_0000, 1'b0};
        tbl[10] = '{32'hFF80_0000, 32'h7FC0_0000, 1'b1};
        tbl[11] = '{32'h8040_0000, 32'h8000_0000, 1'b0};
        tbl[12] = '{32'h7F80_0001, 32'h7FC0_0000, 1'b1};
        tbl[13] = '{32'h0080_0000, 32'h2000_0000, 1'b0};
        tbl[14] = '{32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        x        = '0;
        in_tag   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_y", y, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_nv", 32'(nv), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            issue(tbl[i].x, TW'(i), {tbl[i].nv, tbl[i].y});
        drain();

        lat_op(32'h4080_0000, 6'h11, "latency_single");

        fork
            begin
                for (int t = 0; t < 8; t++)
                    issue_m(rand_x(), TW'(t));
            end
            begin
                repeat (NS + 2) begin
                    @(posedge clk);
                    #1;
                end
                ready_mode = 2;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                ready_mode = 0;
            end
        join
        drain();

        for (int i = 0; i < 1500; i++) begin
            xv = {1'b0, (i % 2 == 1) ? 8'd56 : 8'd55, 23'($urandom)};
            if (i < 2) xv[22:0] = '0;
            else if (i < 4) xv[22:0] = '1;
            issue_m(xv, TW'($urandom));
        end
        drain();

        ready_mode = 1;
        for (int i = 0; i < 1200; i++) begin
            issue_m(rand_x(), TW'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        drain();

        ready_mode = 2;
        for (int k = 0; k < NS + 3; k++) begin
            in_valid = 1'b1;
            x        = rand_x();
            in_tag   = TW'($urandom);
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        x          = 32'h3F80_0000;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int k = 1; k <= NS + 2; k++) begin
            @(negedge clk);
            chk("rst_flush_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        lat_op(32'h4110_0000, 6'h2A, "latency_post_rst");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fsqrt_pipe.md
# fsqrt_pipe

Parametrised, fully pipelined IEEE-754 single-precision square root for the FPU, with correct rounding, a valid/ready handshake with backpressure, and an opaque tag carried alongside each operation. Successor to the fixed-latency `fsqrt` unit: stage count and tag width are configurable, and the result is exact rather than within a few ulp. Sits in the FPU execute stage; the tag carries the destination/flag information that previously used separate `flag`/`add` ports.

## Interface
- `NSTAGE`, 4: pipeline depth in register stages, legal range 1..25.
- `TAG_W`, 6: tag width; the tag is returned unmodified with its result.

- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  unit accepts an operand this cycle.
- `x`  in  32  operand, IEEE single.
- `in_tag`  in  TAG_W  tag for operand.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts a result this cycle.
- `y`  out  32  result, IEEE single.
- `out_tag`  out  TAG_W  tag of result.
- `nv`  out  1  invalid-operation flag for this result.

## Operation
- Accept on `in_valid && in_ready`. Deliver on `out_valid && out_ready`.
- Special cases are decoded at entry and travel down the pipe beside the datapath, checked in this order:
  - NaN (exp=255, mant≠0) gives `y=32'h7FC00000` with `nv=1`.
  - Negative nonzero input (sign=1, exp≠0) gives `y=32'h7FC00000` with `nv=1`. This includes -inf.
  - exp=0 (zero or denormal) gives a signed zero: `y={x[31],31'b0}` with `nv=0`. Denormals are flushed.
  - +inf gives `y=32'h7F800000` with `nv=0`.
- Normal input, exponent `e`, significand `1.m`:
  - `e` odd: radicand `R={1,m}`, result exp `(e+127)>>1`.
  - `e` even: radicand `R={1,m}<<1`, result exp `(e+126)>>1`.
- Root computation:
  - Digit-recurrence (restoring or non-restoring) radix-2 square root produces 25 root bits `q[24:0]`: 24 significand bits plus 1 round bit.
  - Stage `k` computes `ceil(25/NSTAGE)` bits. The last stage computes the remainder.
  - Partial root and remainder are registered between stages.
- Rounding is round-to-nearest by `q[0]`: `sig = q[24:1] + q[0]`. A tie is impossible for a square root.
  - If rounding carries out of 24 bits, the significand becomes `1.0` and the exponent increments.
- Results are always normal. No overflow or underflow can occur.
- Tag and special-case fields pipeline with the data. Results emerge in strict issue order.

## Timing
- Latency is exactly `NSTAGE` cycles from accept to `out_valid` when there is no stall. Throughput is 1 op/cycle.
- Stall rule: `stall = out_valid && !out_ready`.
  - While stalled, every stage register holds and no bubble is squeezed.
  - `in_ready = !stall`. This is combinational and depends on `out_ready`.
- A per-stage valid bit tracks occupancy. Bubbles advance normally when there is no stall.
- `y`, `out_tag` and `nv` stay stable while `out_valid && !out_ready`.
- Reset values: all stage valids=0, `out_valid=0`, `in_ready=1` (following the stall rule), `y=0`, `out_tag=0`, `nv=0`.
- Reset mid-flight discards all in-flight operations. `out_valid=0` the cycle after `rst` is sampled high.
- Simultaneous `rst` and accept: reset wins and the operand is dropped.
- `in_valid=0` produces a bubble. Its data and tag are don't-care, but `out_valid` must stay 0 for that slot.

## Test plan
- Directed values, each with `nv=0`:
  - `x=0x40800000` (4.0) gives `y=0x40000000`.
  - `x=0x40000000` gives `y=0x3FB504F3`.
  - `x=0x3F800000` gives `y=0x3F800000`.
  - `x=0x7F800000` gives `y=0x7F800000`.
  - `x=0x80000000` gives `y=0x80000000`.
  - `x=0x00400000` gives `y=0x00000000`.
- Invalid inputs, each with `nv=1`: `x=0xC0800000` gives `y=0x7FC00000`, and `x=0x7FC12345` gives `y=0x7FC00000`.
- Exhaustive sweep: exponent 55 and 56, all 2^23 mantissas, back-to-back with random tags. Require a bit-exact match to a correctly rounded reference and tag/order match. Run at `NSTAGE` = 1, 4 and 25.
- Backpressure: issue 8 ops with tags 0..7 and hold `out_ready=0` for 3 cycles mid-stream.
  - `in_ready=0` throughout the stall.
  - `y` and `out_tag` stay frozen.
  - All 8 results appear in order with no loss or duplication.
- Latency and bubbles: issue one op at cycle 0 with `out_ready=1`. `out_valid` must be 1 only at cycle `NSTAGE`. Random `in_valid` gaps must never produce spurious `out_valid`.
- Reset mid-flight: fill the pipe, then pulse `rst` for 1 cycle.
  - `out_valid=0` on the next cycle and stays 0 until new ops propagate.
  - The first post-reset op appears after `NSTAGE` cycles with the correct value.
